// File: rtl/proab_sched.sv
// Ping-pong bank scheduler: hands the free bank to the producer and the filled
// bank (with its latched frame sum) to proab_calu through start/done handshakes.
module proab_sched #(
    parameter int DW        = 32,
    parameter int DATA_SIZE = 128,
    parameter int TIMEOUT   = 4096,
    parameter int CW        = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          up_done,
    input  logic [DW-1:0] up_sum,
    output logic          up_ready,
    output logic          up_bank,
    input  logic          calu_ready,
    input  logic          calu_done,
    output logic          calu_start,
    output logic [DW-1:0] calu_sum,
    output logic          calu_bank,
    output logic          frame_done,
    output logic [CW-1:0] frame_cnt,
    input  logic          err_clr,
    output logic          err_overrun,
    output logic          err_timeout
);

    // state   | meaning
    // IDLE    | waiting for the read bank to be full and calu to be ready
    // START   | one-cycle calu_start pulse, timeout counter cleared
    // RUN     | calu computing; leave on calu_done or timeout
    // RELEASE | one-cycle frame_done, read bank freed, read pointer flips
    typedef enum logic [1:0] {IDLE, START, RUN, RELEASE} state_t;

    state_t          state, state_nxt;
    logic [1:0]      full;
    logic            wr_ptr, rd_ptr;
    logic [DW-1:0]   sum_q [2];
    logic [CW-1:0]   tcnt;
    logic [CW-1:0]   frame_cnt_q;
    logic            overrun_q, timeout_q;
    logic            fill, timeout_hit;

    // The timeout must be reachable by the counter, and a bank must hold something.
    if (TIMEOUT < 1 || TIMEOUT > 2**CW || DATA_SIZE < 1) begin : g_param_check
        $error("proab_sched: TIMEOUT must be in 1..2**CW and DATA_SIZE >= 1");
    end

    assign fill = up_done & ~full[wr_ptr];

    always_comb begin
        state_nxt   = state;
        timeout_hit = 1'b0;
        case (state)
            IDLE:    if (full[rd_ptr] && calu_ready) state_nxt = START;
            START:   state_nxt = RUN;
            RUN: begin
                if (calu_done) begin
                    state_nxt = RELEASE;
                end else if (tcnt == CW'(TIMEOUT - 1)) begin
                    state_nxt   = RELEASE;
                    timeout_hit = 1'b1;
                end
            end
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full        <= 2'b00;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            sum_q[0]    <= '0;
            sum_q[1]    <= '0;
            tcnt        <= '0;
            frame_cnt_q <= '0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            // Fill and release never touch the same bank, so both may apply.
            if (fill) begin
                full[wr_ptr]  <= 1'b1;
                sum_q[wr_ptr] <= up_sum;
                wr_ptr        <= ~wr_ptr;
            end
            if (state == RELEASE) begin
                full[rd_ptr] <= 1'b0;
                rd_ptr       <= ~rd_ptr;
                frame_cnt_q  <= frame_cnt_q + CW'(1);
            end
            if (state == START) begin
                tcnt <= '0;
            end else if (state == RUN) begin
                tcnt <= tcnt + CW'(1);
            end
            overrun_q <= (up_done & full[wr_ptr]) | (overrun_q & ~err_clr);
            timeout_q <= timeout_hit | (timeout_q & ~err_clr);
        end
    end

    assign up_ready    = ~full[wr_ptr];
    assign up_bank     = wr_ptr;
    assign calu_bank   = rd_ptr;
    assign calu_sum    = sum_q[rd_ptr];
    assign calu_start  = (state == START);
    assign frame_done  = (state == RELEASE);
    assign frame_cnt   = frame_cnt_q;
    assign err_overrun = overrun_q;
    assign err_timeout = timeout_q;

endmodule

// File: tb/tb_proab_sched.sv
// Self-checking bench for proab_sched: directed vector table, hand sequences for
// ready/timeout/reset corners, and random traffic against a frame-queue model.
module tb_proab_sched;
    localparam int DW = 32;
    localparam int CW = 16;
    localparam int TIMEOUT = 16;

    logic          clk = 1'b0, rst = 1'b0;
    logic          up_done = 1'b0, calu_ready = 1'b1, calu_done = 1'b0, err_clr = 1'b0;
    logic [DW-1:0] up_sum = '0;
    logic          up_ready, up_bank, calu_start, calu_bank, frame_done;
    logic          err_overrun, err_timeout;
    logic [DW-1:0] calu_sum;
    logic [CW-1:0] frame_cnt;

    int n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    proab_sched #(.DW(DW), .DATA_SIZE(128), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .up_done(up_done), .up_sum(up_sum), .up_ready(up_ready), .up_bank(up_bank),
        .calu_ready(calu_ready), .calu_done(calu_done), .calu_start(calu_start),
        .calu_sum(calu_sum), .calu_bank(calu_bank), .frame_done(frame_done),
        .frame_cnt(frame_cnt), .err_clr(err_clr), .err_overrun(err_overrun),
        .err_timeout(err_timeout)
    );

    typedef struct packed {
        logic          ur, ub, cs, cb;
        logic [DW-1:0] sum;
        logic          fd;
        logic [CW-1:0] fc;
        logic          ov, to;
    } outs_t;

    typedef struct {
        logic          rst_v, ud;
        logic [DW-1:0] us;
        logic          cd, ec;
        outs_t         exp;
    } vec_t;

    // Reference model: the full banks are a FIFO of sums; the frame in flight
    // is tracked by its age in cycles since its start pulse.
    logic [DW-1:0] q[$];
    logic [DW-1:0] bank_sum [2];
    int            n_fill, n_rel, age, rel_at;
    logic [CW-1:0] m_frames;
    logic          m_ov, m_to;

    function automatic outs_t dut_outs();
        outs_t o;
        o = {up_ready, up_bank, calu_start, calu_bank, calu_sum, frame_done, frame_cnt,
             err_overrun, err_timeout};
        return o;
    endfunction

    function automatic outs_t eo(logic ur, logic ub, logic cs, logic cb, logic [DW-1:0] s,
                                 logic fd, logic [CW-1:0] fc, logic ov, logic to);
        outs_t o;
        o = {ur, ub, cs, cb, s, fd, fc, ov, to};
        return o;
    endfunction

    function automatic vec_t mk(logic r, logic ud, logic [DW-1:0] us, logic cd, logic ec,
                                outs_t e);
        vec_t v;
        v.rst_v = r; v.ud = ud; v.us = us; v.cd = cd; v.ec = ec; v.exp = e;
        return v;
    endfunction

    function automatic outs_t model_outs();
        outs_t o;
        o.ur  = (q.size() < 2);
        o.ub  = n_fill[0];
        o.cs  = (age == 0);
        o.cb  = n_rel[0];
        o.sum = bank_sum[n_rel & 1];
        o.fd  = (age >= 0 && age == rel_at);
        o.fc  = m_frames;
        o.ov  = m_ov;
        o.to  = m_to;
        return o;
    endfunction

    task automatic model_reset();
        q.delete();
        bank_sum[0] = '0; bank_sum[1] = '0;
        n_fill = 0; n_rel = 0; age = -1; rel_at = -1;
        m_frames = '0; m_ov = 1'b0; m_to = 1'b0;
    endtask

    task automatic model_step();
        bit fill_ok, tmo_now;
        fill_ok = up_done && (q.size() < 2);
        tmo_now = 1'b0;
        if (age >= 0 && age == rel_at) begin
            void'(q.pop_front());
            n_rel++;
            m_frames = m_frames + 1'b1;
            age = -1;
        end else if (age >= 0) begin
            if (age >= 1 && rel_at < 0) begin
                if (calu_done) rel_at = age + 1;
                else if (age == TIMEOUT) begin
                    rel_at = age + 1;
                    tmo_now = 1'b1;
                end
            end
            age++;
        end else if (q.size() > 0 && calu_ready) begin
            age = 0;
            rel_at = -1;
        end
        if (fill_ok) begin
            bank_sum[n_fill & 1] = up_sum;
            q.push_back(up_sum);
            n_fill++;
        end
        m_ov = (up_done && !fill_ok) || (m_ov && !err_clr);
        m_to = tmo_now || (m_to && !err_clr);
    endtask

    task automatic check(string name, outs_t got, outs_t exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_v(string name, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_reset(); else model_step();
        #1;
        check("model", dut_outs(), model_outs());
    endtask

    task automatic cyc(logic ud, logic [DW-1:0] us, logic cd, logic ec);
        up_done = ud; up_sum = us; calu_done = cd; err_clr = ec;
        tick();
        up_done = 1'b0; calu_done = 1'b0; err_clr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        tick();
        rst = 1'b1;
    endtask

    task automatic wait_start(string name);
        for (int i = 0; i < 20; i++) begin
            if (calu_start) return;
            tick();
        end
        check_v({name, "_start_timeout"}, 32'(calu_start), 32'd1);
    endtask

    vec_t tbl[$];
    int   k;
    logic [CW-1:0] fc0;

    initial begin
        model_reset();
        // single frame
        tbl.push_back(mk(0, 0, 0, 0, 0, eo(1, 0, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mk(1, 1, 32'h40400000, 0, 0, eo(1, 1, 0, 0, 32'h40400000, 0, 0, 0, 0)));
        tbl.push_back(mk(1, 0, 0, 0, 0, eo(1, 1, 1, 0, 32'h40400000, 0, 0, 0, 0)));
        tbl.push_back(mk(1, 0, 0, 0, 0, eo(1, 1, 0, 0, 32'h40400000, 0, 0, 0, 0)));
        tbl.push_back(mk(1, 0, 0, 1, 0, eo(1, 1, 0, 0, 32'h40400000, 1, 0, 0, 0)));
        tbl.push_back(mk(1, 0, 0, 0, 0, eo(1, 1, 0, 1, 0, 0, 1, 0, 0)));
        // two fills back-to-back, overrun with clear, then in-order compute
        tbl.push_back(mk(0, 0, 0, 0, 0, eo(1, 0, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mk(1, 1, 32'h10000000, 0, 0, eo(1, 1, 0, 0, 32'h10000000, 0, 0, 0, 0)));
        tbl.push_back(mk(1, 1, 32'h3F800000, 0, 0, eo(0, 0, 1, 0, 32'h10000000, 0, 0, 0, 0)));
        tbl.push_back(mk(1, 0, 0, 0, 0, eo(0, 0, 0, 0, 32'h10000000, 0, 0, 0, 0)));
        tbl.push_back(mk(1, 1, 32'hDEADBEEF, 0, 0, eo(0, 0, 0, 0, 32'h10000000, 0, 0, 1, 0)));
        tbl.push_back(mk(1, 1, 32'hCAFEF00D, 0, 1, eo(0, 0, 0, 0, 32'h10000000, 0, 0, 1, 0)));
        tbl.push_back(mk(1, 0, 0, 0, 1, eo(0, 0, 0, 0, 32'h10000000, 0, 0, 0, 0)));
        tbl.push_back(mk(1, 0, 0, 1, 0, eo(0, 0, 0, 0, 32'h10000000, 1, 0, 0, 0)));
        tbl.push_back(mk(1, 0, 0, 0, 0, eo(1, 0, 0, 1, 32'h3F800000, 0, 1, 0, 0)));
        tbl.push_back(mk(1, 0, 0, 0, 0, eo(1, 0, 1, 1, 32'h3F800000, 0, 1, 0, 0)));
        tbl.push_back(mk(1, 0, 0, 0, 0, eo(1, 0, 0, 1, 32'h3F800000, 0, 1, 0, 0)));
        tbl.push_back(mk(1, 0, 0, 1, 0, eo(1, 0, 0, 1, 32'h3F800000, 1, 1, 0, 0)));
        tbl.push_back(mk(1, 0, 0, 0, 0, eo(1, 0, 0, 0, 32'h10000000, 0, 2, 0, 0)));
        tbl.push_back(mk(1, 0, 0, 1, 0, eo(1, 0, 0, 0, 32'h10000000, 0, 2, 0, 0)));

        foreach (tbl[i]) begin
            rst = tbl[i].rst_v;
            cyc(tbl[i].ud, tbl[i].us, tbl[i].cd, tbl[i].ec);
            check($sformatf("vec%0d", i), dut_outs(), tbl[i].exp);
        end
        rst = 1'b1;

        // start held off by calu_ready
        do_reset();
        calu_ready = 1'b0;
        cyc(1, 32'h12345678, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_v("ready_hold_start", 32'(calu_start), 32'd0);
        end
        calu_ready = 1'b1;
        tick();
        check_v("ready_start", 32'(calu_start), 32'd1);
        check_v("ready_sum", calu_sum, 32'h12345678);
        tick();
        cyc(0, 0, 1, 0);
        check_v("ready_frame_done", 32'(frame_done), 32'd1);
        tick();

        // timeout with no calu_done
        cyc(1, 32'h0BADF00D, 0, 0);
        wait_start("tmo");
        fc0 = frame_cnt;
        k = 0;
        for (int i = 0; i < 40 && !frame_done; i++) begin
            check_v("tmo_err_early", 32'(err_timeout), 32'd0);
            tick();
            k++;
        end
        check_v("tmo_latency", 32'(k), 32'(TIMEOUT + 1));
        check_v("tmo_err", 32'(err_timeout), 32'd1);
        tick();
        check_v("tmo_up_ready", 32'(up_ready), 32'd1);
        check_v("tmo_frame_cnt", 32'(frame_cnt), 32'(fc0 + 1'b1));
        cyc(0, 0, 0, 1);
        check_v("tmo_err_clr", 32'(err_timeout), 32'd0);

        // reset in the middle of RUN
        do_reset();
        cyc(1, 32'h55AA55AA, 0, 0);
        wait_start("rst");
        tick();
        tick();
        #2 rst = 1'b0;
        model_reset();
        #1;
        check("rst_immediate", dut_outs(), eo(1, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        rst = 1'b1;
        cyc(0, 0, 1, 0);
        check_v("rst_late_done_fd", 32'(frame_done), 32'd0);
        tick();
        check_v("rst_late_done_fc", 32'(frame_cnt), 32'd0);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) != 0);
            calu_ready = ($urandom_range(0, 9) < 7);
            cyc($urandom_range(0, 9) < 3, $urandom, $urandom_range(0, 19) < 2,
                $urandom_range(0, 19) == 0);
        end
        rst = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
